// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver states and 8N1 framing constants
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchronizer for a single asynchronous input
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// rtl/uart_byte_receiver.sv - 8N1 UART byte receiver with framing-error and break handling
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_tick,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_baud
      $error("uart_byte_receiver: CLK_HZ/BAUD must be at least 8");
    end
  endgenerate

  logic           rx_s;
  uart_rx_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]     idx_q;
  logic [7:0]     shift_q;
  logic [7:0]     rx_data_q;
  logic           rx_tick_q;
  logic           frame_err_q;

  bit_sync #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk (clk),
    .rst (rst),
    .d_i (RxD),
    .q_o (rx_s)
  );

  // Stop bit is judged at its midpoint, so IDLE is re-entered half a bit early
  // and a directly following start bit is never missed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_tick_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_tick_q   <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == IDX_LAST) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              rx_data_q <= shift_q;
              rx_tick_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_tick   = rx_tick_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb/tb_uart_byte_receiver.sv - directed vector bench for uart_byte_receiver
module tb_uart_byte_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic [7:0] rx_data;
  logic       rx_tick;
  logic       frame_err;

  uart_byte_receiver #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .RxD       (RxD),
    .rx_data   (rx_data),
    .rx_tick   (rx_tick),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int tick_cnt = 0;
  int err_cnt  = 0;
  int viol     = 0;
  int last_tick_cyc = 0;
  int prev_tick_cyc = 0;
  logic tick_prev = 1'b0;
  logic err_prev  = 1'b0;
  logic [7:0] tick_hist[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_tick) begin
      tick_cnt++;
      prev_tick_cyc = last_tick_cyc;
      last_tick_cyc = cyc;
      tick_hist.push_back(rx_data);
    end
    if (frame_err) err_cnt++;
    if (rx_tick && frame_err) viol++;
    if ((rx_tick && tick_prev) || (frame_err && err_prev)) viol++;
    tick_prev = rx_tick;
    err_prev  = frame_err;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_ticks;
    int         exp_errs;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    RxD = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic good_frame(input string name, input logic [7:0] d);
    int t0;
    int e0;
    t0 = tick_cnt;
    e0 = err_cnt;
    send_frame(d, 1'b1, 2 * CPB);
    #1;
    chk({name, "_ticks"}, tick_cnt - t0, 1);
    chk({name, "_errs"}, err_cnt - e0, 0);
    chk({name, "_data"}, int'(rx_data), int'(d));
  endtask

  initial begin
    int t0;
    int e0;
    int start_cyc;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[3] = '{8'h55, 1'b0, 8'hFF, 0, 1};
    vecs[4] = '{8'h3C, 1'b1, 8'h3C, 1, 0};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};
    vecs[6] = '{8'h7E, 1'b0, 8'h81, 0, 1};
    vecs[7] = '{8'h01, 1'b1, 8'h01, 1, 0};
    vecs[8] = '{8'h80, 1'b1, 8'h80, 1, 0};

    rst = 1'b1;
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_tick", int'(rx_tick), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      t0 = tick_cnt;
      e0 = err_cnt;
      start_cyc = cyc;
      send_frame(vecs[i].data, vecs[i].stop, 2 * CPB);
      #1;
      chk($sformatf("vec%0d_ticks", i), tick_cnt - t0, vecs[i].exp_ticks);
      chk($sformatf("vec%0d_errs", i), err_cnt - e0, vecs[i].exp_errs);
      chk($sformatf("vec%0d_data", i), int'(rx_data), int'(vecs[i].exp_data));
      if (i == 0) begin
        n_total++;
        if ((last_tick_cyc - start_cyc) < 153 || (last_tick_cyc - start_cyc) > 155) begin
          n_bad++;
          $display("FAIL latency: got %0d cycles required 153..155", last_tick_cyc - start_cyc);
        end
      end
    end

    // back-to-back frames with no idle gap
    t0 = tick_cnt;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 2 * CPB);
    #1;
    chk("b2b_ticks", tick_cnt - t0, 2);
    chk("b2b_spacing", last_tick_cyc - prev_tick_cyc, 160);
    chk("b2b_first", int'(tick_hist[tick_hist.size() - 2]), 8'h00);
    chk("b2b_second", int'(tick_hist[tick_hist.size() - 1]), 8'hFF);

    // 3-cycle glitch
    t0 = tick_cnt;
    e0 = err_cnt;
    RxD = 1'b0;
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("glitch_state_idle", int'(dut.state_q), int'(uart_pkg::IDLE));
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_ticks", tick_cnt - t0, 0);
    chk("glitch_errs", err_cnt - e0, 0);
    good_frame("after_glitch", 8'h3C);

    // 30 bit-time break
    t0 = tick_cnt;
    e0 = err_cnt;
    RxD = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #1;
    chk("break_errs", err_cnt - e0, 1);
    chk("break_ticks", tick_cnt - t0, 0);
    good_frame("after_break", 8'h81);

    // reset during data bit 4 of 0x7E
    t0 = tick_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int b = 0; b < 4; b++) send_bit(b == 0 ? 1'b0 : 1'b1);
    RxD = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rx_data", int'(rx_data), 0);
    chk("midrst_rx_tick", int'(rx_tick), 0);
    chk("midrst_frame_err", int'(frame_err), 0);
    chk("midrst_state_idle", int'(dut.state_q), int'(uart_pkg::IDLE));
    repeat (3 * CPB) @(negedge clk);
    #1;
    chk("midrst_ticks", tick_cnt - t0, 0);
    chk("midrst_errs", err_cnt - e0, 0);
    good_frame("after_rst", 8'h81);

    chk("strobe_protocol_violations", viol, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
